// File: rtl/snn_pkg.sv
// Shared types and default widths for the spiking-network datapath
// (spike-gating stage and LIF neuron).
package snn_pkg;

  localparam int SNN_W_WIDTH = 4;
  localparam int SNN_V_WIDTH = 8;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_e;

endpackage

// File: rtl/lif_neuron_if.sv
// Weighted-spike input and neuron status outputs. The neuron is the slave;
// the upstream gating stage (or a bench) is the master.
interface lif_neuron_if #(
  parameter int W_WIDTH = 4,
  parameter int V_WIDTH = 8
);
  logic               in_valid;
  logic [W_WIDTH-1:0] in_weight;
  logic               spike_out;
  logic [V_WIDTH-1:0] v_mem;
  logic               refractory;

  modport master (
    output in_valid, in_weight,
    input  spike_out, v_mem, refractory
  );

  modport slave (
    input  in_valid, in_weight,
    output spike_out, v_mem, refractory
  );
endinterface

// File: rtl/lif_sat_update.sv
// Combinational membrane update: add the gated weight, subtract the leak
// with a floor at zero, clamp at full scale, and flag a threshold crossing.
module lif_sat_update
  import snn_pkg::*;
#(
  parameter int W_WIDTH = SNN_W_WIDTH,
  parameter int V_WIDTH = SNN_V_WIDTH,
  parameter int THRESH  = 32,
  parameter int LEAK    = 1
) (
  input  logic [V_WIDTH-1:0] v_cur,
  input  logic               in_valid,
  input  logic [W_WIDTH-1:0] in_weight,
  output logic [V_WIDTH-1:0] v_next,
  output logic               fire
);

  // One extra bit of headroom so the add never wraps before clamping.
  localparam logic [V_WIDTH:0]   LEAK_X   = (V_WIDTH+1)'(LEAK);
  localparam logic [V_WIDTH:0]   MAX_X    = {1'b0, {V_WIDTH{1'b1}}};
  localparam logic [V_WIDTH-1:0] THRESH_V = V_WIDTH'(THRESH);

  logic [V_WIDTH:0] w;
  logic [V_WIDTH:0] sum;
  logic [V_WIDTH:0] leaked;

  // Gate, accumulate, leak with zero floor, saturate at 2^V_WIDTH-1.
  always_comb begin
    w = '0;
    if (in_valid) w = {{(V_WIDTH+1-W_WIDTH){1'b0}}, in_weight};
    sum    = {1'b0, v_cur} + w;
    leaked = (sum > LEAK_X) ? (sum - LEAK_X) : '0;
    v_next = (leaked > MAX_X) ? MAX_X[V_WIDTH-1:0] : leaked[V_WIDTH-1:0];
    fire   = (v_next >= THRESH_V);
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating membrane, one-cycle output
// spike on threshold crossing, then a fixed refractory hold-off.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int W_WIDTH = SNN_W_WIDTH,
  parameter int V_WIDTH = SNN_V_WIDTH,
  parameter int THRESH  = 32,
  parameter int LEAK    = 1,
  parameter int REFRAC  = 3
) (
  input  logic clk,
  input  logic rst,
  lif_neuron_if.slave io
);

  localparam int CW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  lif_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [V_WIDTH-1:0] v_q, v_d;
  logic               spike_q, spike_d;

  logic [V_WIDTH-1:0] v_next;
  logic               fire;

  lif_sat_update #(
    .W_WIDTH (W_WIDTH),
    .V_WIDTH (V_WIDTH),
    .THRESH  (THRESH),
    .LEAK    (LEAK)
  ) u_upd (
    .v_cur     (v_q),
    .in_valid  (io.in_valid),
    .in_weight (io.in_weight),
    .v_next    (v_next),
    .fire      (fire)
  );

  // Next-state: integrate/fire, or count down the refractory window while
  // dropping any input that arrives.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    spike_d = 1'b0;
    case (state_q)
      INTEGRATE: begin
        if (fire) begin
          spike_d = 1'b1;
          v_d     = '0;
          if (REFRAC > 0) begin
            state_d = REFRACTORY;
            cnt_d   = CW'(REFRAC);
          end
        end else begin
          v_d = v_next;
        end
      end
      REFRACTORY: begin
        v_d   = '0;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = INTEGRATE;
      end
      default: state_d = INTEGRATE;
    endcase
  end

  // State registers; reset wins over any same-cycle fire or countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INTEGRATE;
      cnt_q   <= '0;
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      spike_q <= spike_d;
    end
  end

  assign io.spike_out  = spike_q;
  assign io.v_mem      = v_q;
  assign io.refractory = (state_q == REFRACTORY);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: default config (A), THRESH=255 for the
// clamp case (B), and REFRAC=0/THRESH=14 for back-to-back firing (C).
module tb_lif_neuron;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lif_neuron_if #(.W_WIDTH(4), .V_WIDTH(8)) ifa ();
  lif_neuron_if #(.W_WIDTH(4), .V_WIDTH(8)) ifb ();
  lif_neuron_if #(.W_WIDTH(4), .V_WIDTH(8)) ifc ();

  lif_neuron #(.THRESH(32),  .LEAK(1), .REFRAC(3)) dut_a (.clk(clk), .rst(rst), .io(ifa));
  lif_neuron #(.THRESH(255), .LEAK(1), .REFRAC(3)) dut_b (.clk(clk), .rst(rst), .io(ifb));
  lif_neuron #(.THRESH(14),  .LEAK(1), .REFRAC(0)) dut_c (.clk(clk), .rst(rst), .io(ifc));

  // Advance one clock; outputs are stable 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic v, input logic [3:0] w);
    ifa.in_valid = v; ifa.in_weight = w;
    ifb.in_valid = v; ifb.in_weight = w;
    ifc.in_valid = v; ifc.in_weight = w;
  endtask

  task automatic do_reset();
    drive_all(1'b0, 4'd0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ifa.v_mem !== 8'd0 || ifa.spike_out !== 1'b0 || ifa.refractory !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: v=%0d spk=%b ref=%b expected 0/0/0", ifa.v_mem, ifa.spike_out, ifa.refractory);
    end
    checks++;
    if (ifb.v_mem !== 8'd0 || ifb.spike_out !== 1'b0 || ifb.refractory !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: v=%0d spk=%b ref=%b expected 0/0/0", ifb.v_mem, ifb.spike_out, ifb.refractory);
    end
    checks++;
    if (ifc.v_mem !== 8'd0 || ifc.spike_out !== 1'b0 || ifc.refractory !== 1'b0) begin
      errors++;
      $display("FAIL reset_c: v=%0d spk=%b ref=%b expected 0/0/0", ifc.v_mem, ifc.spike_out, ifc.refractory);
    end
  endtask

  // 15,15,15 -> 14, 28, fire; 3 refractory cycles drop inputs; then 14.
  task automatic test_fire_refrac();
    logic [7:0] exp_v [3] = '{8'd14, 8'd28, 8'd0};
    logic       exp_s [3] = '{1'b0, 1'b0, 1'b1};
    logic       exp_r [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    drive_all(1'b1, 4'd15);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ifa.v_mem !== exp_v[i] || ifa.spike_out !== exp_s[i] || ifa.refractory !== exp_r[i]) begin
        errors++;
        $display("FAIL integrate[%0d]: v=%0d spk=%b ref=%b expected %0d/%b/%b",
                 i, ifa.v_mem, ifa.spike_out, ifa.refractory, exp_v[i], exp_s[i], exp_r[i]);
      end
    end
    // Three inputs sampled while refractory is high; the last one drops it.
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ifa.v_mem !== 8'd0 || ifa.spike_out !== 1'b0 || ifa.refractory !== (i < 2)) begin
        errors++;
        $display("FAIL refrac[%0d]: v=%0d spk=%b ref=%b expected 0/0/%b",
                 i, ifa.v_mem, ifa.spike_out, ifa.refractory, (i < 2));
      end
    end
    step();
    checks++;
    if (ifa.v_mem !== 8'd14 || ifa.refractory !== 1'b0 || ifa.spike_out !== 1'b0) begin
      errors++;
      $display("FAIL post_refrac: v=%0d ref=%b spk=%b expected 14/0/0", ifa.v_mem, ifa.refractory, ifa.spike_out);
    end
  endtask

  // Reach 28, then leak-only down to 0 and hold; also a valid weight-0 cycle.
  task automatic test_leak_decay();
    logic [7:0] ev;
    do_reset();
    drive_all(1'b1, 4'd15);
    step();
    step();
    checks++;
    if (ifa.v_mem !== 8'd28) begin
      errors++;
      $display("FAIL decay_start: v=%0d expected 28", ifa.v_mem);
    end
    drive_all(1'b0, 4'd15);
    ev = 8'd28;
    for (int i = 0; i < 31; i++) begin
      step();
      ev = (ev > 8'd0) ? ev - 8'd1 : 8'd0;
      checks++;
      if (ifa.v_mem !== ev || ifa.spike_out !== 1'b0) begin
        errors++;
        $display("FAIL decay[%0d]: v=%0d spk=%b expected %0d/0", i, ifa.v_mem, ifa.spike_out, ev);
      end
    end
    drive_all(1'b1, 4'd15);
    step();
    drive_all(1'b1, 4'd0);
    step();
    checks++;
    if (ifa.v_mem !== 8'd13) begin
      errors++;
      $display("FAIL zero_weight_leak: v=%0d expected 13", ifa.v_mem);
    end
  endtask

  // THRESH=255: 14k up to 252, then 252+15-1=266 clamps to 255 and fires.
  task automatic test_clamp();
    do_reset();
    drive_all(1'b1, 4'd15);
    for (int i = 1; i <= 18; i++) begin
      step();
      checks++;
      if (ifb.v_mem !== 8'(14 * i) || ifb.spike_out !== 1'b0) begin
        errors++;
        $display("FAIL clamp_ramp[%0d]: v=%0d spk=%b expected %0d/0", i, ifb.v_mem, ifb.spike_out, 14 * i);
      end
    end
    step();
    checks++;
    if (ifb.spike_out !== 1'b1 || ifb.v_mem !== 8'd0 || ifb.refractory !== 1'b1) begin
      errors++;
      $display("FAIL clamp_fire: spk=%b v=%0d ref=%b expected 1/0/1", ifb.spike_out, ifb.v_mem, ifb.refractory);
    end
  endtask

  // rst in the 2nd refractory cycle, and rst on a would-be threshold crossing.
  task automatic test_reset_priority();
    do_reset();
    drive_all(1'b1, 4'd15);
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (ifa.v_mem !== 8'd0 || ifa.refractory !== 1'b0 || ifa.spike_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_refrac: v=%0d ref=%b spk=%b expected 0/0/0", ifa.v_mem, ifa.refractory, ifa.spike_out);
    end
    step();
    checks++;
    if (ifa.v_mem !== 8'd14 || ifa.refractory !== 1'b0) begin
      errors++;
      $display("FAIL rst_then_accept: v=%0d ref=%b expected 14/0", ifa.v_mem, ifa.refractory);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (ifa.v_mem !== 8'd0 || ifa.spike_out !== 1'b0 || ifa.refractory !== 1'b0) begin
      errors++;
      $display("FAIL rst_over_fire: v=%0d spk=%b ref=%b expected 0/0/0", ifa.v_mem, ifa.spike_out, ifa.refractory);
    end
  endtask

  // REFRAC=0, THRESH=14: every 15 input fires, refractory never rises.
  task automatic test_back_to_back();
    do_reset();
    drive_all(1'b1, 4'd15);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ifc.spike_out !== 1'b1 || ifc.v_mem !== 8'd0 || ifc.refractory !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d]: spk=%b v=%0d ref=%b expected 1/0/0", i, ifc.spike_out, ifc.v_mem, ifc.refractory);
      end
    end
    drive_all(1'b0, 4'd0);
    step();
    checks++;
    if (ifc.spike_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: spk=%b expected 0", ifc.spike_out);
    end
  endtask

  initial begin
    drive_all(1'b0, 4'd0);
    test_reset();
    test_fire_refrac();
    test_leak_decay();
    test_clamp();
    test_reset_priority();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
